cpu_operand_fetch: RTL and testbench

- Pipeline stage p2→p3. Takes the raw register-file read data for the p2 instruction and applies forwarding from p3 (execute) and p4 (writeback).
- Detects load-use hazards and inserts bubbles. Registers operands and destination info into the p3 pipeline register.
- Sits between the register file (read ports, write port p4) and the execute stage. Keeps a saturating load-use stall counter for performance monitoring.

---
 rtl/cpu_operand_fetch.sv | 137 +++++++++++++
 tb/tb_cpu_operand_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_operand_fetch.sv
// Operand fetch stage (p2 -> p3): forwards results from execute and
// writeback onto the register-file read data, inserts a single bubble on a
// load-use hazard, and registers operands and destination info into the p3
// pipeline register. Also counts load-use bubbles in a saturating counter.
module cpu_operand_fetch #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 p2_valid,
  input  logic [4:0]           p2_reg_a,
  input  logic [4:0]           p2_reg_b,
  input  logic                 p2_use_a,
  input  logic                 p2_use_b,
  input  logic [XLEN-1:0]      p2_reg_data_a,
  input  logic [XLEN-1:0]      p2_reg_data_b,
  input  logic [XLEN-1:0]      p2_literal,
  input  logic                 p2_use_literal,
  input  logic [4:0]           p2_reg_d,
  input  logic                 p2_write_en,
  input  logic                 p2_is_load,
  input  logic [XLEN-1:0]      p3_alu_result,
  input  logic                 p3_stall_in,
  input  logic                 p3_flush,
  input  logic [4:0]           p4_reg_d,
  input  logic                 p4_write_en,
  input  logic [XLEN-1:0]      p4_reg_data_d,
  output logic                 p2_stall,
  output logic                 p3_valid,
  output logic [XLEN-1:0]      p3_op_a,
  output logic [XLEN-1:0]      p3_op_b,
  output logic [4:0]           p3_reg_d,
  output logic                 p3_write_en,
  output logic                 p3_is_load,
  output logic [CNT_WIDTH-1:0] load_use_count
);

  logic                 valid_q, valid_d;
  logic                 we_q, we_d;
  logic                 ld_q, ld_d;
  logic [4:0]           rd_q, rd_d;
  logic [XLEN-1:0]      op_a_q, op_a_d;
  logic [XLEN-1:0]      op_b_q, op_b_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b_next;
  logic            p3_alu_wr;
  logic            hazard;

  // Only a non-load p3 instruction has its result available this cycle;
  // a load result appears one cycle later through the p4 path.
  assign p3_alu_wr = valid_q & we_q & ~ld_q;

  // Forwarding mux for operand A: r0 first, then youngest writer wins.
  always_comb begin
    fwd_a = p2_reg_data_a;
    if (p2_reg_a == 5'd0)                       fwd_a = '0;
    else if (p3_alu_wr && rd_q == p2_reg_a)     fwd_a = p3_alu_result;
    else if (p4_write_en && p4_reg_d == p2_reg_a) fwd_a = p4_reg_data_d;
  end

  // Forwarding mux for operand B, same priority as A.
  always_comb begin
    fwd_b = p2_reg_data_b;
    if (p2_reg_b == 5'd0)                       fwd_b = '0;
    else if (p3_alu_wr && rd_q == p2_reg_b)     fwd_b = p3_alu_result;
    else if (p4_write_en && p4_reg_d == p2_reg_b) fwd_b = p4_reg_data_d;
  end

  assign op_b_next = p2_use_literal ? p2_literal : fwd_b;

  // A literal-replaced B operand never reads the register, so it cannot
  // depend on the load in p3.
  assign hazard = p2_valid & valid_q & we_q & ld_q & (rd_q != 5'd0) &
                  ((p2_use_a & (p2_reg_a == rd_q)) |
                   (p2_use_b & ~p2_use_literal & (p2_reg_b == rd_q)));

  assign p2_stall = p2_valid & (p3_stall_in | (hazard & ~p3_flush));

  // Next-state for the p3 register: stall holds, flush/hazard bubble,
  // otherwise capture p2. Operands may go stale inside a bubble.
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    ld_d    = ld_q;
    rd_d    = rd_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    if (p3_stall_in) begin
      // hold everything
    end else if (p3_flush || hazard) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      ld_d    = 1'b0;
      if (!p3_flush && cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else begin
      valid_d = p2_valid;
      we_d    = p2_valid & p2_write_en;
      ld_d    = p2_valid & p2_is_load;
      rd_d    = p2_reg_d;
      op_a_d  = fwd_a;
      op_b_d  = op_b_next;
    end
  end

  // p3 pipeline register and stall counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      rd_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign p3_valid       = valid_q;
  assign p3_write_en    = we_q;
  assign p3_is_load     = ld_q;
  assign p3_reg_d       = rd_q;
  assign p3_op_a        = op_a_q;
  assign p3_op_b        = op_b_q;
  assign load_use_count = cnt_q;

endmodule

// File: tb/tb_cpu_operand_fetch.sv
// Directed bench for cpu_operand_fetch: expected p3 register contents are
// queued when a step is driven and compared after the capturing edge.
module tb_cpu_operand_fetch;

  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            p2_valid, p2_use_a, p2_use_b, p2_use_literal, p2_write_en, p2_is_load;
  logic [4:0]      p2_reg_a, p2_reg_b, p2_reg_d, p4_reg_d;
  logic [XLEN-1:0] p2_reg_data_a, p2_reg_data_b, p2_literal, p3_alu_result, p4_reg_data_d;
  logic            p3_stall_in, p3_flush, p4_write_en;
  logic            p2_stall, p3_valid, p3_write_en, p3_is_load;
  logic [XLEN-1:0] p3_op_a, p3_op_b;
  logic [4:0]      p3_reg_d;
  logic [CW-1:0]   load_use_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic            v, we, ld;
    logic [4:0]      rd;
    logic [XLEN-1:0] a, b;
    bit              chk_ops;
  } exp_t;
  exp_t sb[$];

  cpu_operand_fetch #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .p2_valid(p2_valid), .p2_reg_a(p2_reg_a), .p2_reg_b(p2_reg_b),
    .p2_use_a(p2_use_a), .p2_use_b(p2_use_b),
    .p2_reg_data_a(p2_reg_data_a), .p2_reg_data_b(p2_reg_data_b),
    .p2_literal(p2_literal), .p2_use_literal(p2_use_literal),
    .p2_reg_d(p2_reg_d), .p2_write_en(p2_write_en), .p2_is_load(p2_is_load),
    .p3_alu_result(p3_alu_result), .p3_stall_in(p3_stall_in), .p3_flush(p3_flush),
    .p4_reg_d(p4_reg_d), .p4_write_en(p4_write_en), .p4_reg_data_d(p4_reg_data_d),
    .p2_stall(p2_stall), .p3_valid(p3_valid), .p3_op_a(p3_op_a), .p3_op_b(p3_op_b),
    .p3_reg_d(p3_reg_d), .p3_write_en(p3_write_en), .p3_is_load(p3_is_load),
    .load_use_count(load_use_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    p2_valid = 0; p2_reg_a = 0; p2_reg_b = 0; p2_use_a = 0; p2_use_b = 0;
    p2_reg_data_a = 0; p2_reg_data_b = 0; p2_literal = 0; p2_use_literal = 0;
    p2_reg_d = 0; p2_write_en = 0; p2_is_load = 0; p3_alu_result = 0;
    p3_stall_in = 0; p3_flush = 0; p4_reg_d = 0; p4_write_en = 0; p4_reg_data_d = 0;
  endtask

  task automatic p2(input logic [4:0] ra, input logic [XLEN-1:0] da,
                    input logic [4:0] rb, input logic [XLEN-1:0] db,
                    input logic [4:0] rd, input logic we, input logic ld);
    p2_valid = 1; p2_use_a = 1; p2_use_b = 1; p2_use_literal = 0;
    p2_reg_a = ra; p2_reg_data_a = da; p2_reg_b = rb; p2_reg_data_b = db;
    p2_reg_d = rd; p2_write_en = we; p2_is_load = ld;
  endtask

  task automatic push(input logic v, input logic we, input logic ld, input logic [4:0] rd,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit chk);
    exp_t e;
    e.v = v; e.we = we; e.ld = ld; e.rd = rd; e.a = a; e.b = b; e.chk_ops = chk;
    sb.push_back(e);
  endtask

  task automatic stall_chk(input string tag, input logic expv);
    #1;
    cmp(tag, {63'd0, p2_stall}, {63'd0, expv});
  endtask

  // Advance one edge and compare the p3 register against the queued entry.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      cmp({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      cmp({tag, "_valid"}, {63'd0, p3_valid}, {63'd0, e.v});
      cmp({tag, "_we"}, {63'd0, p3_write_en}, {63'd0, e.we});
      cmp({tag, "_ld"}, {63'd0, p3_is_load}, {63'd0, e.ld});
      if (e.v) cmp({tag, "_rd"}, {59'd0, p3_reg_d}, {59'd0, e.rd});
      if (e.chk_ops) begin
        cmp({tag, "_op_a"}, {32'd0, p3_op_a}, {32'd0, e.a});
        cmp({tag, "_op_b"}, {32'd0, p3_op_b}, {32'd0, e.b});
      end
    end
  endtask

  task automatic all_zero(input string tag);
    cmp({tag, "_valid"}, {63'd0, p3_valid}, 64'd0);
    cmp({tag, "_we"}, {63'd0, p3_write_en}, 64'd0);
    cmp({tag, "_ld"}, {63'd0, p3_is_load}, 64'd0);
    cmp({tag, "_rd"}, {59'd0, p3_reg_d}, 64'd0);
    cmp({tag, "_op_a"}, {32'd0, p3_op_a}, 64'd0);
    cmp({tag, "_op_b"}, {32'd0, p3_op_b}, 64'd0);
    cmp({tag, "_cnt"}, {60'd0, load_use_count}, 64'd0);
  endtask

  initial begin
    idle();
    #2;
    all_zero("reset");
    #10 reset = 1'b0;                  // t=12, between edges

    // plain regfile read, nothing in flight
    p2(5'd1, 32'h11, 5'd2, 32'h22, 5'd5, 1, 0);
    stall_chk("plain_stall", 0);
    push(1, 1, 0, 5'd5, 32'h11, 32'h22, 1);
    step("plain");

    // p3 ALU writes r5, p4 writes r5 too: p3 wins
    p2(5'd5, 32'h0, 5'd6, 32'h66, 5'd6, 1, 0);
    p3_alu_result = 32'hDEAD; p4_write_en = 1; p4_reg_d = 5'd5; p4_reg_data_d = 32'hBEEF;
    push(1, 1, 0, 5'd6, 32'hDEAD, 32'h66, 1);
    step("p3_fwd");

    // p4 forwards r7 over stale regfile data
    p2(5'd1, 32'h11, 5'd7, 32'h0, 5'd0, 0, 0);
    p3_alu_result = 32'h9999; p4_reg_d = 5'd7; p4_reg_data_d = 32'h1234;
    push(1, 0, 0, 5'd0, 32'h11, 32'h1234, 1);
    step("p4_fwd");

    // literal replaces B; this instruction writes r0 via ALU
    p2(5'd1, 32'h11, 5'd7, 32'h0, 5'd0, 1, 0);
    p2_use_literal = 1; p2_literal = 32'h55;
    push(1, 1, 0, 5'd0, 32'h11, 32'h55, 1);
    step("literal");

    // r0 reads as zero even with p3 writing r0; next instruction is load r3
    p2(5'd0, 32'h77, 5'd0, 32'h88, 5'd3, 1, 1);
    p3_alu_result = 32'hFFFF; p4_write_en = 0;
    push(1, 1, 1, 5'd3, 32'h0, 32'h0, 1);
    step("r0");

    // load-use on r3 -> one bubble
    p2(5'd3, 32'h0, 5'd4, 32'h44, 5'd3, 1, 1);
    stall_chk("lu_stall", 1);
    push(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    step("lu_bubble");
    cmp("lu_cnt", {60'd0, load_use_count}, 64'd1);

    // load now in p4 supplies r3
    p4_write_en = 1; p4_reg_d = 5'd3; p4_reg_data_d = 32'hCAFE;
    stall_chk("lu_release_stall", 0);
    push(1, 1, 1, 5'd3, 32'hCAFE, 32'h44, 1);
    step("lu_p4");

    // load r3 in p3, but p2 only names r3 as literal-replaced B
    p2(5'd1, 32'h11, 5'd3, 32'h0, 5'd9, 1, 0);
    p2_use_literal = 1; p2_literal = 32'h77; p4_write_en = 0;
    stall_chk("lit_nostall", 0);
    push(1, 1, 0, 5'd9, 32'h11, 32'h77, 1);
    step("lit_noh");
    cmp("lit_cnt", {60'd0, load_use_count}, 64'd1);

    // execute stall for 3 cycles: p3 holds
    p2(5'd2, 32'hAB, 5'd4, 32'h44, 5'd10, 1, 0);
    p3_stall_in = 1;
    stall_chk("hold_stall", 1);
    for (int i = 0; i < 3; i++) begin
      push(1, 1, 0, 5'd9, 32'h11, 32'h77, 1);
      step("hold");
    end

    // flush kills p2 instruction
    p3_stall_in = 0; p3_flush = 1;
    stall_chk("flush_stall", 0);
    push(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
    step("flush");
    cmp("flush_cnt", {60'd0, load_use_count}, 64'd1);

    // refill then async reset between edges
    p3_flush = 0;
    push(1, 1, 0, 5'd10, 32'hAB, 32'h44, 1);
    step("refill");
    #3 reset = 1'b1;
    #1 all_zero("midreset");
    #1 reset = 1'b0;

    // saturation: load r3 reading r3 alternates advance / bubble
    idle();
    p2(5'd3, 32'h0, 5'd0, 32'h0, 5'd3, 1, 1);
    p2_use_b = 0;
    push(1, 1, 1, 5'd3, 32'h0, 32'h0, 0);
    step("sat_fill");
    for (int i = 0; i < 20; i++) begin
      stall_chk("sat_stall", 1);
      push(0, 0, 0, 5'd0, 32'h0, 32'h0, 0);
      step("sat_bub");
      cmp("sat_cnt", {60'd0, load_use_count}, (i + 1 > 15) ? 64'd15 : 64'(i + 1));
      push(1, 1, 1, 5'd3, 32'h0, 32'h0, 0);
      step("sat_adv");
    end
    cmp("sat_final", {60'd0, load_use_count}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
